// File: rtl/apb_slave_regbank_pkg.sv
// Shared definitions for the APB register-bank completer.
// Contents:
//   apb_state_e - transfer phase enumeration (IDLE, SETUP, ACCESS)
//   NUM_SLOTS   - number of banks, one per pselx line
//   ID_BASE     - upper bits of the read-only ID register at index 0
//   calcError   - decides whether a transfer seen in its setup cycle is errored
package apb_slave_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    localparam int NUM_SLOTS = 3;
    localparam logic [31:0] ID_BASE = 32'hB00B_0000;

    // A transfer is errored when the select is not one-hot, the address
    // reaches past the bank inside the 4 KB window, the address is not
    // word aligned, or it tries to write the read-only ID register.
    function automatic logic calcError(
        input logic [NUM_SLOTS-1:0] sel,
        input logic [31:0]          addr,
        input logic                 write,
        input int                   idxw
    );
        logic       oneHot;
        logic [11:0] hiBits;
        logic [9:0]  idxBits;
        oneHot  = (sel != '0) && ((sel & (sel - NUM_SLOTS'(1))) == '0);
        hiBits  = addr[11:0] >> (idxw + 2);
        idxBits = addr[11:2] & ((10'd1 << idxw) - 10'd1);
        return !oneHot || (hiBits != '0) || (addr[1:0] != 2'b00) ||
               (write && (idxBits == '0));
    endfunction

endpackage

// File: rtl/apb_slave_regbank_if.sv
// APB completer-side bus bundle.
// Signals:
//   pselx   - one-hot bank select (requester -> completer)
//   penable - access-phase strobe
//   pwrite  - 1 = write, 0 = read
//   paddr   - byte address
//   pwdata  - write data
//   prdata  - registered read data (completer -> requester)
//   pready  - transfer completes this cycle
//   pslverr - error response, meaningful only with pready
interface apb_slave_regbank_if;
    import apb_slave_pkg::*;

    logic [NUM_SLOTS-1:0] pselx;
    logic                 penable;
    logic                 pwrite;
    logic [31:0]          paddr;
    logic [31:0]          pwdata;
    logic [31:0]          prdata;
    logic                 pready;
    logic                 pslverr;

    modport master (
        output pselx, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  pselx, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );

endinterface

// File: rtl/apb_slave_regbank_bank.sv
// One register bank: index 0 is a read-only ID, the rest are read/write.
// Ports:
//   hclk    - clock, rising edge
//   hresetn - synchronous active-high reset, clears all R/W registers
//   we      - write enable for the register at idx
//   idx     - word index
//   wdata   - write data
//   rdata   - combinational read data of the register at idx
module apb_regbank
    import apb_slave_pkg::*;
#(
    parameter int NUM_REGS = 8,
    parameter int SLOT_ID  = 0,
    parameter int IDXW     = $clog2(NUM_REGS)
) (
    input  logic            hclk,
    input  logic            hresetn,
    input  logic            we,
    input  logic [IDXW-1:0] idx,
    input  logic [31:0]     wdata,
    output logic [31:0]     rdata
);

    // Storage starts at index 1; index 0 is a constant and has no flops.
    logic [31:0] regs_q [1:NUM_REGS-1];

    // Synchronous write of the addressed R/W register.
    always_ff @(posedge hclk) begin
        if (hresetn) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (idx == IDXW'(i)) begin
                    regs_q[i] <= wdata;
                end
            end
        end
    end

    // Combinational read; falls back to the ID value for index 0.
    always_comb begin
        rdata = ID_BASE | 32'(SLOT_ID);
        for (int i = 1; i < NUM_REGS; i++) begin
            if (idx == IDXW'(i)) begin
                rdata = regs_q[i];
            end
        end
    end

endmodule

// File: rtl/apb_slave_regbank.sv
// APB completer with three independent register banks and programmable
// wait states.
// Ports:
//   hclk    - clock, rising edge
//   hresetn - synchronous active-high reset
//   bus     - APB completer modport (pselx/penable/pwrite/paddr/pwdata in,
//             prdata/pready/pslverr out)
module apb_slave_regbank
    import apb_slave_pkg::*;
#(
    parameter int NUM_REGS    = 8,
    parameter int WAIT_STATES = 0
) (
    input  logic                hclk,
    input  logic                hresetn,
    apb_slave_regbank_if.slave  bus
);

    localparam int IDXW = $clog2(NUM_REGS);

    apb_state_e           state_q, state_d, phase;
    logic [3:0]           waitCnt_q, waitCnt_d;
    logic [NUM_SLOTS-1:0] sel_q, sel_d;
    logic [IDXW-1:0]      idx_q, idx_d;
    logic [31:0]          wdata_q, wdata_d;
    logic                 write_q, write_d;
    logic                 err_q, err_d;
    logic [31:0]          prdata_q, prdata_d;

    logic [IDXW-1:0]      busIdx;
    logic                 busErr;
    logic [31:0]          busRead;
    logic [IDXW-1:0]      bankIdx;
    logic [31:0]          bankRdata [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] bankWe;
    logic                 readyInt;
    logic                 commit;

    assign busIdx   = bus.paddr[IDXW+1:2];
    assign busErr   = calcError(bus.pselx, bus.paddr, bus.pwrite, IDXW);
    assign readyInt = (state_q == ACCESS) && (waitCnt_q == 4'd0);

    // Banks see the live bus index during setup (for the read) and the
    // latched index during access (for the write).
    assign bankIdx  = (state_q == ACCESS) ? idx_q : busIdx;

    for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_bank
        assign bankWe[k] = commit && sel_q[k];
        apb_regbank #(
            .NUM_REGS (NUM_REGS),
            .SLOT_ID  (k),
            .IDXW     (IDXW)
        ) u_bank (
            .hclk    (hclk),
            .hresetn (hresetn),
            .we      (bankWe[k]),
            .idx     (bankIdx),
            .wdata   (wdata_q),
            .rdata   (bankRdata[k])
        );
    end

    // OR-mux of the selected bank; errored selects are discarded later.
    always_comb begin
        busRead = '0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            if (bus.pselx[k]) begin
                busRead = busRead | bankRdata[k];
            end
        end
    end

    // The setup cycle is recognised straight from the bus while the state
    // register still says IDLE, so the access phase starts on the very next
    // edge and a completed transfer can be followed by a new setup at once.
    always_comb begin
        phase = state_q;
        if (state_q == IDLE && (bus.pselx != '0) && !bus.penable) begin
            phase = SETUP;
        end
    end

    // Next-state, latching and commit decisions for the current phase.
    always_comb begin
        state_d   = state_q;
        waitCnt_d = waitCnt_q;
        sel_d     = sel_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        write_d   = write_q;
        err_d     = err_q;
        prdata_d  = prdata_q;
        commit    = 1'b0;
        case (phase)
            IDLE: begin
                state_d = IDLE;
            end
            SETUP: begin
                state_d   = ACCESS;
                sel_d     = bus.pselx;
                idx_d     = busIdx;
                write_d   = bus.pwrite;
                wdata_d   = bus.pwdata;
                waitCnt_d = 4'(WAIT_STATES);
                err_d     = busErr;
                if (!bus.pwrite) begin
                    prdata_d = busErr ? '0 : busRead;
                end
            end
            ACCESS: begin
                if (bus.pselx == '0) begin
                    state_d = IDLE;
                end else begin
                    if (waitCnt_q != 4'd0) begin
                        waitCnt_d = waitCnt_q - 4'd1;
                    end
                    if (readyInt && bus.penable) begin
                        commit  = write_q && !err_q;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and transfer-context registers.
    always_ff @(posedge hclk) begin
        if (hresetn) begin
            state_q   <= IDLE;
            waitCnt_q <= '0;
            sel_q     <= '0;
            idx_q     <= '0;
            wdata_q   <= '0;
            write_q   <= 1'b0;
            err_q     <= 1'b0;
            prdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            waitCnt_q <= waitCnt_d;
            sel_q     <= sel_d;
            idx_q     <= idx_d;
            wdata_q   <= wdata_d;
            write_q   <= write_d;
            err_q     <= err_d;
            prdata_q  <= prdata_d;
        end
    end

    assign bus.prdata  = prdata_q;
    assign bus.pready  = readyInt;
    assign bus.pslverr = readyInt && err_q;

endmodule

// File: doc/apb_slave_regbank.md
# apb_slave_regbank

APB completer that consumes the bridge's APB outputs (`pselx`, `penable`, `pwrite`, `paddr`, `pwdata`) and returns `prdata`, `pready` and `pslverr`. It implements three independent 32-bit register banks, one per `pselx` line, with programmable wait states. It is the peripheral endpoint of the AHB→APB path: write and read transfers issued by the AHB master terminate here.

## Interface
- `NUM_REGS`, 8: registers per bank, power of two, 2..256; `IDXW = log2(NUM_REGS)`.
- `WAIT_STATES`, 0: extra access-phase cycles before `pready`, 0..15.
- `hclk` in 1: the single clock; all logic on the rising edge.
- `hresetn` in 1: reset, synchronous and active-high; asserted `1` means reset.
- `pselx` in 3: one-hot bank select; bit k selects bank k.
- `penable` in 1: APB access-phase strobe.
- `pwrite` in 1: 1 means write, 0 means read.
- `paddr` in 32: byte address; word index is `paddr[IDXW+1:2]`.
- `pwdata` in 32: write data.
- `prdata` out 32: read data, registered.
- `pready` out 1: transfer completes this cycle.
- `pslverr` out 1: error response, valid only while `pready=1`.

## Operation
- **FSM states:** IDLE, SETUP, ACCESS.
- **IDLE → SETUP:** when any `pselx` bit is 1 and `penable=0`.
- **SETUP → ACCESS:** unconditionally on the next edge. On that edge:
  - latch the bank, index, `pwrite` and `pwdata`;
  - load the wait counter with `WAIT_STATES`;
  - compute the error flag;
  - for reads, load `prdata` with the selected register, or `0` on error.
- **ACCESS:**
  - `pready = (cnt==0)`; the counter decrements each cycle while nonzero.
  - When `pready=1` and `penable=1`: a non-error write commits on that edge, then the FSM goes to IDLE.
  - A new setup cycle in the following cycle is accepted directly from IDLE.
- **Error flag** (`pslverr`) is set when any of these holds; an errored transfer never modifies any register:
  - `pselx` is not one-hot;
  - `paddr[11:IDXW+2]` is nonzero;
  - `paddr[1:0]` is nonzero;
  - the transfer is a write to index 0.
- **Index 0** of each bank is a read-only ID register with value `32'hB00B_0000 | k`, where k is the bank number.
- **Indices 1..NUM_REGS-1** are read/write and reset to `0`.
- `paddr[31:12]` is ignored.
- **Protocol violations:**
  - `penable=1` while in IDLE: ignored, stay in IDLE.
  - `pselx` dropping to `0` during ACCESS before `pready`: abort to IDLE with no write; `prdata` keeps its last value.
- `prdata` holds its value until the next read's SETUP→ACCESS edge.
- `pready` and `pslverr` are `0` outside ACCESS.

## Timing
- **Reset values:** `prdata=0`, `pready=0`, `pslverr=0`, FSM in IDLE, counter `0`, all R/W registers `0`.
- **Reset mid-transfer:** forces IDLE on the next edge; any pending write is dropped.
- **Latency with WAIT_STATES=0:** setup at cycle T, access at T+1 with `pready=1` and `prdata` valid. The write is visible to a read whose setup is at T+2.
- **Latency with WAIT_STATES=N:** `pready` rises at T+1+N. `prdata` is already valid at T+1 and stable through completion.
- **Back-to-back transfers:** one transfer per 2+N cycles.
- **Read-after-write to the same register:** returns the new data.

## Structure
- **Package `apb_slave_pkg`:**
  - FSM state enum `{IDLE, SETUP, ACCESS}`;
  - `NUM_SLOTS = 3`;
  - `ID_BASE = 32'hB00B_0000`;
  - error-condition helper function.
- **Sub-module `apb_regbank`:** one bank with parameters `NUM_REGS` and `SLOT_ID`.
  - Ports: `hclk`, `hresetn`, `we`, `idx`, `wdata`, `rdata`.
  - Behaviour: combinational read, synchronous write.
  - Instantiated three times.
- **Top level** holds the FSM, wait counter, decode/error logic and the `prdata` register.
- Target size: about 200 lines.

## Test plan
- **Reset:** hold `hresetn=1` for 2 cycles, then release → `prdata=0`, `pready=0`, `pslverr=0`. A read of bank 1 at `paddr=0x0` returns `32'hB00B_0001`.
- **Single write then read** (WAIT_STATES=0): write `pselx=3'b001`, `paddr=0x8`, `pwdata=32'hDEADBEEF` → `pready=1` at the access cycle, `pslverr=0`. A read of the same address returns `32'hDEADBEEF`; bank 2 index 2 still reads `0`.
- **Wait states** (WAIT_STATES=3): read at setup cycle T → `pready=0` at T+1..T+3, `pready=1` at T+4, `prdata` stable T+1..T+4.
- **Errors:** each of the following → `pslverr=1` with `pready=1`, and a follow-up read shows the target unchanged:
  - write to `paddr=0x0`;
  - write to `paddr=0x40` (out of range, NUM_REGS=8);
  - `pselx=3'b011`.
- **Abort and mid-reset:** drop `pselx` to `0` in the access cycle of a write `0x12345678` to `paddr=0x4` → register remains `0`. Assert `hresetn` during ACCESS of a write → no commit, all outputs `0` next cycle.
- **Back-to-back:** alternate writes of `0x1..0x7` to indices 1..7 of bank 2 with no idle cycles → all complete in 2 cycles each, and read-back matches.
